motor_ramp_ctrl: RTL and testbench

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

---
 rtl/motor_ramp_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: two-channel signed duty ramp generator with a small register
// bank, a tick-based watchdog and an emergency-stop latch feeding the PWM stage.
module motor_ramp_ctrl #(
    parameter int TICK_DIV = 1000,
    parameter int DUTY_MAX = 1023
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    input  logic        estop,
    output logic [9:0]  duty_l,
    output logic [9:0]  duty_r,
    output logic        dir_l,
    output logic        dir_r,
    output logic        fabint
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic signed [10:0] DMAX_POS = 11'(DUTY_MAX);
    localparam logic signed [10:0] DMAX_NEG = 11'(-DUTY_MAX);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_TGT_L  = 8'h04;
    localparam logic [7:0] ADDR_TGT_R  = 8'h08;
    localparam logic [7:0] ADDR_STEP   = 8'h0C;
    localparam logic [7:0] ADDR_WDOG   = 8'h10;
    localparam logic [7:0] ADDR_STATUS = 8'h14;
    localparam logic [7:0] ADDR_CUR_L  = 8'h18;
    localparam logic [7:0] ADDR_CUR_R  = 8'h1C;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ESTOP   = 2'b10
    } state_t;

    state_t             state_r;
    logic [2:0]         ctrl_r;
    logic signed [10:0] tgt_l_r;
    logic signed [10:0] tgt_r_r;
    logic signed [10:0] cur_l_r;
    logic signed [10:0] cur_r_r;
    logic [7:0]         step_r;
    logic [15:0]        wdog_reload_r;
    logic [15:0]        wdog_cnt_r;
    logic               timeout_r;
    logic               estop_seen_r;
    logic [PW-1:0]      presc_r;

    logic               tick_s;
    logic               wr_ctrl_s;
    logic               wr_tgt_l_s;
    logic               wr_tgt_r_s;
    logic               wr_step_s;
    logic               wr_wdog_s;
    logic               wr_status_s;
    logic               clr_timeout_s;
    logic               clr_estop_s;
    logic               en_keep_s;
    logic               wdog_reload_s;
    logic               expire_s;
    logic signed [10:0] eff_tgt_l_s;
    logic signed [10:0] eff_tgt_r_s;
    logic signed [10:0] ramp_l_s;
    logic signed [10:0] ramp_r_s;
    logic               unused_wdata_s;

    function automatic logic signed [10:0] sat_tgt(input logic signed [10:0] v);
        logic signed [10:0] r;
        if (v > DMAX_POS) begin
            r = DMAX_POS;
        end else if (v < DMAX_NEG) begin
            r = DMAX_NEG;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Distance is taken in 12 bits so a full-scale sign reversal cannot overflow.
    function automatic logic signed [10:0] ramp_step(input logic signed [10:0] cur,
                                                     input logic signed [10:0] tgt,
                                                     input logic [7:0]         step);
        logic signed [11:0] diff;
        logic signed [11:0] stp;
        logic signed [11:0] res;
        diff = {tgt[10], tgt} - {cur[10], cur};
        stp  = {4'b0000, step};
        if (diff > stp) begin
            res = {cur[10], cur} + stp;
        end else if (diff < -stp) begin
            res = {cur[10], cur} - stp;
        end else begin
            res = {tgt[10], tgt};
        end
        return res[10:0];
    endfunction

    assign unused_wdata_s = ^bus_write_data[31:16];

    // Write decode, watchdog events and the ramp step for this cycle
    always_comb begin
        tick_s        = (presc_r == PRESC_LAST);
        wr_ctrl_s     = bus_write_en && (bus_addr == ADDR_CTRL);
        wr_tgt_l_s    = bus_write_en && (bus_addr == ADDR_TGT_L);
        wr_tgt_r_s    = bus_write_en && (bus_addr == ADDR_TGT_R);
        wr_step_s     = bus_write_en && (bus_addr == ADDR_STEP);
        wr_wdog_s     = bus_write_en && (bus_addr == ADDR_WDOG);
        wr_status_s   = bus_write_en && (bus_addr == ADDR_STATUS);
        clr_timeout_s = wr_status_s && bus_write_data[0];
        clr_estop_s   = wr_status_s && bus_write_data[1] && !estop;
        en_keep_s     = ctrl_r[0] && !(wr_ctrl_s && !bus_write_data[0]);
        wdog_reload_s = wr_tgt_l_s || wr_tgt_r_s ||
                        (wr_ctrl_s && bus_write_data[1] && !ctrl_r[1]);
        expire_s      = tick_s && (state_r == ST_RUN) && ctrl_r[1] &&
                        (wdog_cnt_r <= 16'd1) && !wdog_reload_s && !estop;
        if (state_r == ST_TIMEOUT) begin
            eff_tgt_l_s = 11'sd0;
            eff_tgt_r_s = 11'sd0;
        end else begin
            eff_tgt_l_s = tgt_l_r;
            eff_tgt_r_s = tgt_r_r;
        end
        ramp_l_s = ramp_step(cur_l_r, eff_tgt_l_s, step_r);
        ramp_r_s = ramp_step(cur_r_r, eff_tgt_r_s, step_r);
    end

    // Duty magnitude, direction and interrupt decoded from registered state
    always_comb begin
        dir_l  = cur_l_r[10];
        dir_r  = cur_r_r[10];
        duty_l = cur_l_r[10] ? 10'(-cur_l_r) : cur_l_r[9:0];
        duty_r = cur_r_r[10] ? 10'(-cur_r_r) : cur_r_r[9:0];
        fabint = ctrl_r[2] && (timeout_r || estop_seen_r);
    end

    // Register read mux
    always_comb begin
        if (bus_read_en) begin
            case (bus_addr)
                ADDR_CTRL:   bus_read_data = {29'd0, ctrl_r};
                ADDR_TGT_L:  bus_read_data = {21'd0, tgt_l_r};
                ADDR_TGT_R:  bus_read_data = {21'd0, tgt_r_r};
                ADDR_STEP:   bus_read_data = {24'd0, step_r};
                ADDR_WDOG:   bus_read_data = {16'd0, wdog_reload_r};
                ADDR_STATUS: bus_read_data = {28'd0, state_r, estop_seen_r, timeout_r};
                ADDR_CUR_L:  bus_read_data = {21'd0, cur_l_r};
                ADDR_CUR_R:  bus_read_data = {21'd0, cur_r_r};
                default:     bus_read_data = 32'd0;
            endcase
        end else begin
            bus_read_data = 32'd0;
        end
    end

    // Registers, prescaler, watchdog, ramp and mode FSM
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state_r       <= ST_RUN;
            ctrl_r        <= 3'd0;
            tgt_l_r       <= 11'sd0;
            tgt_r_r       <= 11'sd0;
            cur_l_r       <= 11'sd0;
            cur_r_r       <= 11'sd0;
            step_r        <= 8'd0;
            wdog_reload_r <= 16'd0;
            wdog_cnt_r    <= 16'd0;
            timeout_r     <= 1'b0;
            estop_seen_r  <= 1'b0;
            presc_r       <= {PW{1'b0}};
        end else begin
            presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            if (wr_ctrl_s)  ctrl_r        <= bus_write_data[2:0];
            if (wr_tgt_l_s) tgt_l_r       <= sat_tgt(bus_write_data[10:0]);
            if (wr_tgt_r_s) tgt_r_r       <= sat_tgt(bus_write_data[10:0]);
            if (wr_step_s)  step_r        <= bus_write_data[7:0];
            if (wr_wdog_s)  wdog_reload_r <= bus_write_data[15:0];

            if (estop)              estop_seen_r <= 1'b1;
            else if (clr_estop_s)   estop_seen_r <= 1'b0;
            if (expire_s)           timeout_r    <= 1'b1;
            else if (clr_timeout_s) timeout_r    <= 1'b0;

            if (wdog_reload_s) begin
                wdog_cnt_r <= wdog_reload_r;
            end else if (tick_s && state_r == ST_RUN && ctrl_r[1] && !estop &&
                         wdog_cnt_r != 16'd0) begin
                wdog_cnt_r <= wdog_cnt_r - 16'd1;
            end

            if (estop || state_r == ST_ESTOP || !en_keep_s) begin
                cur_l_r <= 11'sd0;
                cur_r_r <= 11'sd0;
            end else if (tick_s) begin
                cur_l_r <= ramp_l_s;
                cur_r_r <= ramp_r_s;
            end

            if (estop) begin
                state_r <= ST_ESTOP;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (expire_s) state_r <= ST_TIMEOUT;
                    end
                    ST_TIMEOUT: begin
                        if (!timeout_r || clr_timeout_s) begin
                            state_r    <= ST_RUN;
                            wdog_cnt_r <= wdog_reload_r;
                        end
                    end
                    ST_ESTOP: begin
                        if (!estop_seen_r || clr_estop_s) begin
                            state_r    <= ST_RUN;
                            wdog_cnt_r <= wdog_reload_r;
                        end
                    end
                    default: state_r <= ST_RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with TICK_DIV=4: ramping, sign crossing,
// watchdog timeout, estop latch, target saturation and reset behaviour.
module tb_motor_ramp_ctrl;
    logic        pclk;
    logic        nreset;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        estop;
    logic [9:0]  duty_l;
    logic [9:0]  duty_r;
    logic        dir_l;
    logic        dir_r;
    logic        fabint;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_TGT_L  = 8'h04;
    localparam logic [7:0] A_TGT_R  = 8'h08;
    localparam logic [7:0] A_STEP   = 8'h0C;
    localparam logic [7:0] A_WDOG   = 8'h10;
    localparam logic [7:0] A_STATUS = 8'h14;
    localparam logic [7:0] A_CUR_L  = 8'h18;
    localparam logic [7:0] A_CUR_R  = 8'h1C;

    motor_ramp_ctrl #(.TICK_DIV(4), .DUTY_MAX(1023)) dut (
        .pclk           (pclk),
        .nreset         (nreset),
        .bus_write_en   (bus_write_en),
        .bus_read_en    (bus_read_en),
        .bus_addr       (bus_addr),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .estop          (estop),
        .duty_l         (duty_l),
        .duty_r         (duty_r),
        .dir_l          (dir_l),
        .dir_r          (dir_r),
        .fabint         (fabint)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        bus_read_en = 1'b1;
        bus_addr    = a;
        #1;
        d           = bus_read_data;
        bus_read_en = 1'b0;
        bus_addr    = 8'h00;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus_write_en   = 1'b1;
        bus_addr       = a;
        bus_write_data = d;
        @(negedge pclk);
        bus_write_en   = 1'b0;
        bus_write_data = 32'h0;
        bus_addr       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic expect_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_rd(a, v);
        check_val(tag, v, exp);
    endtask

    task automatic wait_change(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] old;
        logic [31:0] v;
        int n;
        bus_rd(a, old);
        v = old;
        n = 0;
        while (n < 24 && v == old) begin
            @(negedge pclk);
            bus_rd(a, v);
            n++;
        end
        check_val({tag, "_seen"}, {31'd0, (v != old)}, 32'd1);
        check_val(tag, v, exp);
    endtask

    initial begin
        logic [31:0] s;
        int k;
        nreset = 1'b0; bus_write_en = 1'b0; bus_read_en = 1'b0; estop = 1'b0;
        bus_addr = 8'h00; bus_write_data = 32'h0;
        repeat (3) @(negedge pclk);
        check_val("rst_duty_l", {22'd0, duty_l}, 32'd0);
        check_val("rst_dir_r", {31'd0, dir_r}, 32'd0);
        check_val("rst_fabint", {31'd0, fabint}, 32'd0);
        check_val("rst_rdata", bus_read_data, 32'd0);
        nreset = 1'b1;
        expect_reg("rst_status", A_STATUS, 32'd0);
        expect_reg("rst_ctrl", A_CTRL, 32'd0);

        // Saturation, unmapped and read-only accesses
        bus_wr(A_TGT_L, 32'h400);
        expect_reg("tgt_sat_neg", A_TGT_L, 32'h401);
        expect_reg("unmapped_rd", 8'h20, 32'd0);
        bus_wr(A_CUR_L, 32'h123);
        expect_reg("ro_write_ignored", A_CUR_L, 32'd0);

        // Positive ramp 0 -> 250 in steps of 100
        bus_wr(A_TGT_L, 32'd250);
        bus_wr(A_STEP, 32'd100);
        bus_wr(A_CTRL, 32'h1);
        wait_change("cur_l_100", A_CUR_L, 32'd100);
        wait_change("cur_l_200", A_CUR_L, 32'd200);
        wait_change("cur_l_250", A_CUR_L, 32'd250);
        check_val("duty_l_250", {22'd0, duty_l}, 32'd250);
        check_val("dir_l_fwd", {31'd0, dir_l}, 32'd0);
        idle(8);
        expect_reg("cur_l_hold", A_CUR_L, 32'd250);

        // Right channel +150 then through zero to -150
        bus_wr(A_TGT_R, 32'd150);
        wait_change("cur_r_100", A_CUR_R, 32'd100);
        wait_change("cur_r_150", A_CUR_R, 32'd150);
        bus_wr(A_TGT_R, 32'h76A);
        wait_change("cur_r_50", A_CUR_R, 32'd50);
        check_val("dir_r_at_50", {31'd0, dir_r}, 32'd0);
        wait_change("cur_r_m50", A_CUR_R, 32'h7CE);
        check_val("dir_r_at_m50", {31'd0, dir_r}, 32'd1);
        check_val("duty_r_at_m50", {22'd0, duty_r}, 32'd50);
        wait_change("cur_r_m150", A_CUR_R, 32'h76A);
        check_val("duty_r_at_m150", {22'd0, duty_r}, 32'd150);

        // Disable forces zero; STEP=0 holds
        bus_wr(A_CTRL, 32'h0);
        expect_reg("dis_cur_l", A_CUR_L, 32'd0);
        expect_reg("dis_cur_r", A_CUR_R, 32'd0);
        check_val("dis_dir_r", {31'd0, dir_r}, 32'd0);
        bus_wr(A_STEP, 32'd0);
        bus_wr(A_CTRL, 32'h1);
        idle(12);
        expect_reg("step0_hold", A_CUR_L, 32'd0);

        // Watchdog timeout after 3 ticks
        bus_wr(A_STEP, 32'd100);
        idle(16);
        expect_reg("pre_wd_cur_l", A_CUR_L, 32'd250);
        expect_reg("pre_wd_cur_r", A_CUR_R, 32'h76A);
        bus_wr(A_WDOG, 32'd3);
        bus_wr(A_CTRL, 32'h7);
        k = 0;
        s = 32'd0;
        while (k < 30 && s[0] == 1'b0) begin
            @(negedge pclk);
            k++;
            bus_rd(A_STATUS, s);
        end
        check_val("wd_status", s, 32'h5);
        check_val("wd_three_ticks", {31'd0, (k >= 9 && k <= 12)}, 32'd1);
        check_val("wd_fabint", {31'd0, fabint}, 32'd1);
        bus_wr(A_TGT_L, 32'd300);
        expect_reg("to_tgt_stored", A_TGT_L, 32'd300);
        idle(16);
        expect_reg("to_cur_l_zero", A_CUR_L, 32'd0);
        expect_reg("to_cur_r_zero", A_CUR_R, 32'd0);
        expect_reg("to_still_timeout", A_STATUS, 32'h5);
        bus_wr(A_CTRL, 32'h5);
        bus_wr(A_STATUS, 32'h1);
        expect_reg("to_exit_run", A_STATUS, 32'd0);
        check_val("to_exit_fabint", {31'd0, fabint}, 32'd0);
        wait_change("post_to_ramp", A_CUR_L, 32'd100);

        // Target write on the expiry tick reloads the watchdog instead
        bus_wr(A_STEP, 32'd1);
        bus_wr(A_TGT_L, 32'd1000);
        wait_change("sync_tick", A_CUR_L, 32'd101);
        bus_wr(A_WDOG, 32'd1);
        bus_wr(A_CTRL, 32'h7);
        idle(1);
        bus_wr(A_TGT_L, 32'd1000);
        expect_reg("wd_coincident_write", A_STATUS, 32'd0);
        idle(3);
        expect_reg("wd_before_expiry", A_STATUS, 32'd0);
        idle(1);
        expect_reg("wd_expiry_after_reload", A_STATUS, 32'h5);
        bus_wr(A_CTRL, 32'h5);
        bus_wr(A_STATUS, 32'h1);
        bus_wr(A_STEP, 32'd100);
        bus_wr(A_TGT_L, 32'd500);
        bus_wr(A_TGT_R, 32'd500);

        // Emergency stop mid-ramp
        idle(6);
        estop = 1'b1;
        @(negedge pclk);
        check_val("es_duty_l", {22'd0, duty_l}, 32'd0);
        check_val("es_duty_r", {22'd0, duty_r}, 32'd0);
        expect_reg("es_status", A_STATUS, 32'hA);
        check_val("es_fabint", {31'd0, fabint}, 32'd1);
        bus_wr(A_STATUS, 32'h2);
        expect_reg("es_w1c_ignored", A_STATUS, 32'hA);
        estop = 1'b0;
        idle(3);
        expect_reg("es_sticky", A_STATUS, 32'hA);
        expect_reg("es_cur_held", A_CUR_L, 32'd0);
        bus_wr(A_STATUS, 32'h2);
        expect_reg("es_exit_run", A_STATUS, 32'd0);
        wait_change("es_resume", A_CUR_L, 32'd100);

        // Reset mid-ramp abandons everything
        idle(5);
        nreset = 1'b0;
        @(negedge pclk);
        check_val("mr_duty_l", {22'd0, duty_l}, 32'd0);
        check_val("mr_duty_r", {22'd0, duty_r}, 32'd0);
        check_val("mr_fabint", {31'd0, fabint}, 32'd0);
        expect_reg("mr_tgt_r", A_TGT_R, 32'd0);
        nreset = 1'b1;
        idle(12);
        expect_reg("mr_cur_l", A_CUR_L, 32'd0);
        expect_reg("mr_ctrl", A_CTRL, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
